// File: rtl/adder_pkg.sv
// Shared defaults and elaboration helpers for the pipelined adder family.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    function automatic int unsigned nstg(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Elaboration-time legality check for a WIDTH/CHUNK pair.
    function automatic bit chunk_fits(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit registered slice of the carry chain; cm_o is the combinational
// carry into the slice MSB, used by the top level for signed overflow.
module adder_stage
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             en,
    input  logic             rst,
    input  logic             v_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cm_o,
    output logic             v_o
);

    logic [CHUNK:0]   add_d;
    logic [CHUNK-1:0] s_q;
    logic             c_q;
    logic             v_q;

    always_comb begin
        add_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
        cm_o  = add_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else if (en) begin
            s_q <= add_d[CHUNK-1:0];
            c_q <= add_d[CHUNK];
            v_q <= v_i;
        end
    end

    assign s_o = s_q;
    assign c_o = c_q;
    assign v_o = v_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: NSTG registered CHUNK-bit slices with
// operand skew and sum de-skew, valid/ready on both sides.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTG = nstg(WIDTH, CHUNK);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [NSTG-1:0]  v_w;
    logic [NSTG-1:0]  c_w;
    logic [NSTG-1:0]  cm_w;
    logic             ovf_q;
    logic             unused_cm;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? ~cin : cin;

    // Only the MSB slice's carry-in-to-MSB feeds ovf; the rest are intentionally dropped.
    assign unused_cm = ^cm_w;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [CHUNK-1:0] a_k;
        logic [CHUNK-1:0] b_k;
        logic [CHUNK-1:0] s_k;
        logic             c_k;
        logic             v_k;

        if (k == 0) begin : g_head
            assign a_k = a[CHUNK-1:0];
            assign b_k = b_eff[CHUNK-1:0];
            assign c_k = c0;
            assign v_k = in_valid;
        end else begin : g_skew
            // Chunk k waits k cycles so it meets the carry from slice k-1.
            logic [CHUNK-1:0] skw_a_q [k];
            logic [CHUNK-1:0] skw_b_q [k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < k; i++) begin
                        skw_a_q[i] <= '0;
                        skw_b_q[i] <= '0;
                    end
                end else if (adv) begin
                    skw_a_q[0] <= a[k*CHUNK +: CHUNK];
                    skw_b_q[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int unsigned i = 1; i < k; i++) begin
                        skw_a_q[i] <= skw_a_q[i-1];
                        skw_b_q[i] <= skw_b_q[i-1];
                    end
                end
            end

            assign a_k = skw_a_q[k-1];
            assign b_k = skw_b_q[k-1];
            assign c_k = c_w[k-1];
            assign v_k = v_w[k-1];
        end

        adder_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk  (clk),
            .en   (adv),
            .rst  (rst),
            .v_i  (v_k),
            .a_i  (a_k),
            .b_i  (b_k),
            .c_i  (c_k),
            .s_o  (s_k),
            .c_o  (c_w[k]),
            .cm_o (cm_w[k]),
            .v_o  (v_w[k])
        );

        if (k == NSTG - 1) begin : g_tail
            logic msb_a;
            logic msb_b;
            logic ovf_d;

            assign msb_a = a_k[CHUNK-1];
            assign msb_b = b_k[CHUNK-1];
            // carry-in-to-MSB XOR carry-out-of-MSB, registered beside the last slice.
            assign ovf_d = cm_w[k] ? ~(msb_a | msb_b) : (msb_a & msb_b);

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign sum[k*CHUNK +: CHUNK] = s_k;
        end else begin : g_deskew
            localparam int unsigned DEPTH = NSTG - 1 - k;
            logic [CHUNK-1:0] dsk_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        dsk_q[i] <= '0;
                    end
                end else if (adv) begin
                    dsk_q[0] <= s_k;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        dsk_q[i] <= dsk_q[i-1];
                    end
                end
            end

            assign sum[k*CHUNK +: CHUNK] = dsk_q[DEPTH-1];
        end
    end

    assign out_valid = v_w[NSTG-1];
    assign cout      = c_w[NSTG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed + random bench for pipelined_adder against a slot-level reference model.
module tb_pipelined_adder;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int N = 4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    res_t        md [N];
    logic        mv [N];
    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned handoffs = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Arithmetic reference: unsigned carry/borrow and signed range test.
    function automatic res_t ref_calc(input logic [15:0] x, input logic [15:0] y,
                                      input logic ci, input logic su);
        res_t        r;
        int unsigned ux = x;
        int unsigned uy = y;
        int unsigned ui = ci ? 1 : 0;
        int          sx = $signed(x);
        int          sy = $signed(y);
        int          si = ci ? 1 : 0;
        int          sres;
        if (!su) begin
            r.s  = 16'(ux + uy + ui);
            r.c  = (ux + uy + ui) > 65535;
            sres = sx + sy + si;
        end else begin
            r.s  = 16'(ux - uy - ui);
            r.c  = ux >= (uy + ui);
            sres = sx - sy - si;
        end
        r.o = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic su, input logic ordy, input logic r,
                        output logic acc);
        logic        adv_m;
        logic        stall;
        logic        hand;
        logic [15:0] ps;
        logic        pc;
        logic        po;
        in_valid  = iv;
        a         = x;
        b         = y;
        cin       = ci;
        sub       = su;
        out_ready = ordy;
        rst       = r;
        #1;
        adv_m = !mv[N-1] || ordy;
        if (!r) check("in_ready", in_ready, adv_m);
        stall = out_valid && !ordy;
        hand  = out_valid && ordy && !r;
        ps = sum;
        pc = cout;
        po = ovf;
        acc = iv && adv_m && !r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
        end else if (adv_m) begin
            for (int i = N - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                md[i] = md[i-1];
            end
            mv[0] = iv;
            md[0] = ref_calc(x, y, ci, su);
        end
        if (hand) handoffs++;
        #1;
        check("out_valid", out_valid, mv[N-1]);
        if (r) begin
            check("rst_sum", sum, 16'h0000);
            check("rst_cout", cout, 1'b0);
            check("rst_ovf", ovf, 1'b0);
        end else begin
            if (mv[N-1]) begin
                check("sum", sum, md[N-1].s);
                check("cout", cout, md[N-1].c);
                check("ovf", ovf, md[N-1].o);
            end
            if (stall) begin
                check("hold_sum", sum, ps);
                check("hold_cout", cout, pc);
                check("hold_ovf", ovf, po);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy, 1'b0, acc);
    endtask

    task automatic wait_valid(input string tag);
        int unsigned n = 0;
        while (!out_valid && n < 12) begin
            idle(1'b1);
            n++;
        end
        check({"timeout_", tag}, out_valid, 1'b1);
    endtask

    initial begin
        logic        acc;
        int          lat;
        int unsigned h0;
        int unsigned sent;
        logic [15:0] ca;
        logic [15:0] cb;
        logic        cc;
        logic        cs;

        for (int i = 0; i < N; i++) mv[i] = 1'b0;

        // Reset held two cycles with a beat offered.
        step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1'b1);

        // Latency and inter-chunk carry.
        step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check("accept_00FF", acc, 1'b1);
        lat = 1;
        while (!out_valid && lat < 12) begin
            idle(1'b1);
            lat++;
        end
        check("latency", 32'(lat), 32'(N));
        check("sum_00FF", sum, 16'h0100);
        check("cout_00FF", cout, 1'b0);
        check("ovf_00FF", ovf, 1'b0);

        // Full ripple, then signed overflow, back to back.
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        wait_valid("ripple");
        check("sum_FFFF", sum, 16'h0000);
        check("cout_FFFF", cout, 1'b1);
        check("ovf_FFFF", ovf, 1'b0);
        idle(1'b1);
        check("sum_7FFF", sum, 16'h8000);
        check("cout_7FFF", cout, 1'b0);
        check("ovf_7FFF", ovf, 1'b1);

        // Subtract cases.
        step(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        wait_valid("sub");
        check("sum_5m7", sum, 16'hFFFE);
        check("cout_5m7", cout, 1'b0);
        check("ovf_5m7", ovf, 1'b0);
        idle(1'b1);
        check("sum_8000m1", sum, 16'h7FFF);
        check("cout_8000m1", cout, 1'b1);
        check("ovf_8000m1", ovf, 1'b1);
        for (int i = 0; i < N; i++) idle(1'b1);

        // Eight random beats with out_ready toggling 1,0,1,0...
        h0   = handoffs;
        sent = 0;
        ca = 16'($urandom);
        cb = 16'($urandom);
        cc = 1'($urandom);
        cs = 1'($urandom);
        for (int t = 0; t < 80; t++) begin
            if (sent >= 8 && (handoffs - h0) >= 8) break;
            step(sent < 8, ca, cb, cc, cs, (t % 2) == 0, 1'b0, acc);
            if (acc) begin
                sent++;
                ca = 16'($urandom);
                cb = 16'($urandom);
                cc = 1'($urandom);
                cs = 1'($urandom);
            end
        end
        check("stream_handoffs", handoffs - h0, 8);

        // Reset while three beats are in flight.
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        h0 = handoffs;
        for (int i = 0; i < N + 2; i++) idle(1'b1);
        check("flushed_handoffs", handoffs - h0, 0);
        step(1'b1, 16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        lat = 1;
        while (!out_valid && lat < 12) begin
            idle(1'b1);
            lat++;
        end
        check("latency_after_rst", 32'(lat), 32'(N));
        check("sum_after_rst", sum, 16'h9998);

        // Random soak with bubbles and random backpressure.
        for (int t = 0; t < 60; t++) begin
            step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(3, 0) != 0), 1'b0, acc);
        end
        for (int i = 0; i < N + 2; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
